// File: rtl/sub_byte_transform_if.sv
// State bus for the SubBytes stage: plain state in, substituted state out.
// Bit 0 is the MSB of each word, so byte k sits in [8k:8k+7].
interface sub_byte_transform_if;
   logic [0:127] dataIn;
   logic [0:127] subMat;

   modport master (output dataIn, input subMat);
   modport slave  (input dataIn, output subMat);
endinterface

// File: rtl/sub_byte_transform.sv
// AES-128 SubBytes stage: 16 parallel forward S-box lanes feeding one
// output register that is cleared asynchronously.
module sbox_lane (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   // The FIPS-197 forward table, packed MSB-first: entry v sits at bits [8v:8v+7].
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   always_comb dout = SBOX[{din, 3'b000} +: 8];
endmodule

module sub_byte_transform (
   input logic           clk,
   input logic           rst,
   sub_byte_transform_if.slave bus
);
   localparam int NUM_LANES = 16;

   logic [0:127] sub_d;
   logic [0:127] sub_q;

   // Lanes are fully independent; no row or column mixing happens here.
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      sbox_lane u_lane (
         .din  (bus.dataIn[8*k +: 8]),
         .dout (sub_d[8*k +: 8])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sub_q <= '0;
      else      sub_q <= sub_d;
   end

   assign bus.subMat = sub_q;
endmodule

// File: tb/tb_sub_byte_transform.sv
// Directed bench for the SubBytes stage; the exhaustive sweep is checked
// against an arithmetic GF(2^8) model of the S-box.
module tb_sub_byte_transform;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   sub_byte_transform_if bus ();

   sub_byte_transform dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] v);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (v != 8'h00 && gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   // Advance one edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.dataIn = 128'h001F0E543C4E08596E221B0B4774311A;
      #1;
      checks++;
      if (bus.subMat !== 128'h0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", bus.subMat, 128'h0);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.subMat !== 128'h0) begin
            failures++;
            $display("FAIL reset_hold%0d got=%h exp=%h", i, bus.subMat, 128'h0);
         end
      end
      rst = 1'b1;
      step();
      checks++;
      if (bus.subMat !== 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", bus.subMat,
                  128'h63C0AB20EB2F30CB9F93AF2BA092C7A2);
      end
   endtask

   task automatic test_back_to_back();
      logic [0:127] vin [4];
      logic [0:127] vexp[4];
      vin[0] = 128'h5847088B15B61CBA59D4E2E8CD39DFCE; vexp[0] = 128'h6AA0303D594E9CF4CB48989BBD129E8B;
      vin[1] = 128'h43C6A9620E57C0C80908EBFE3DF87F37; vexp[1] = 128'h1AB4D3AAAB5BBAE80130E9BB2741D29A;
      vin[2] = 128'h7876305470767D23993C375B4B3934F1; vexp[2] = 128'hBC3804205138FF26EEEB9A39B31218A1;
      vin[3] = 128'hB1CA51ED08FC54E104B1C9D3E7B26C20; vexp[3] = 128'hC874D15530B020F8F2C8DD66943750B7;
      bus.dataIn = vin[0];
      #1;
      // Before the edge the register still holds the previous result.
      checks++;
      if (bus.subMat !== 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2) begin
         failures++;
         $display("FAIL stream_latency got=%h exp=%h", bus.subMat,
                  128'h63C0AB20EB2F30CB9F93AF2BA092C7A2);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         if (i < 3) bus.dataIn = vin[i+1];
         checks++;
         if (bus.subMat !== vexp[i]) begin
            failures++;
            $display("FAIL stream%0d got=%h exp=%h", i, bus.subMat, vexp[i]);
         end
      end
      step();
      checks++;
      if (bus.subMat !== vexp[3]) begin
         failures++;
         $display("FAIL stream_hold got=%h exp=%h", bus.subMat, vexp[3]);
      end
   endtask

   task automatic test_sbox_sweep();
      logic [7:0] e;
      for (int v = 0; v < 256; v++) begin
         bus.dataIn = {16{8'(v)}};
         e = sbox_model(8'(v));
         step();
         checks++;
         if (bus.subMat !== {16{e}}) begin
            failures++;
            $display("FAIL sbox_%02h got=%h exp=%h", v, bus.subMat, {16{e}});
         end
      end
      // Anchor values straight from the standard, independent of the model.
      bus.dataIn = {16{8'h00}};
      step();
      checks++;
      if (bus.subMat !== {16{8'h63}}) begin
         failures++;
         $display("FAIL sbox_anchor00 got=%h exp=%h", bus.subMat, {16{8'h63}});
      end
      bus.dataIn = 128'h00010E1F53548BFF00010E1F53548BFF;
      step();
      checks++;
      if (bus.subMat !== 128'h637CABC0ED203D16637CABC0ED203D16) begin
         failures++;
         $display("FAIL sbox_anchors got=%h exp=%h", bus.subMat,
                  128'h637CABC0ED203D16637CABC0ED203D16);
      end
   endtask

   task automatic test_byte_order();
      bus.dataIn = 128'h000102030405060708090A0B0C0D0E0F;
      step();
      checks++;
      if (bus.subMat !== 128'h637C777BF26B6FC53001672BFED7AB76) begin
         failures++;
         $display("FAIL byte_order got=%h exp=%h", bus.subMat,
                  128'h637C777BF26B6FC53001672BFED7AB76);
      end
      bus.dataIn = 128'h000102030405060708090A0B0C0D0EFF;
      step();
      checks++;
      if (bus.subMat !== 128'h637C777BF26B6FC53001672BFED7AB16) begin
         failures++;
         $display("FAIL byte15_only got=%h exp=%h", bus.subMat,
                  128'h637C777BF26B6FC53001672BFED7AB16);
      end
   endtask

   task automatic test_async_reset();
      bus.dataIn = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
      step();
      bus.dataIn = 128'h43C6A9620E57C0C80908EBFE3DF87F37;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.subMat !== 128'h0) begin
         failures++;
         $display("FAIL async_clear got=%h exp=%h", bus.subMat, 128'h0);
      end
      step();
      checks++;
      if (bus.subMat !== 128'h0) begin
         failures++;
         $display("FAIL async_hold got=%h exp=%h", bus.subMat, 128'h0);
      end
      rst = 1'b1;
      bus.dataIn = 128'h7876305470767D23993C375B4B3934F1;
      #2;
      checks++;
      if (bus.subMat !== 128'h0) begin
         failures++;
         $display("FAIL async_release_wait got=%h exp=%h", bus.subMat, 128'h0);
      end
      step();
      checks++;
      if (bus.subMat !== 128'hBC3804205138FF26EEEB9A39B31218A1) begin
         failures++;
         $display("FAIL async_first_edge got=%h exp=%h", bus.subMat,
                  128'hBC3804205138FF26EEEB9A39B31218A1);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.dataIn = '0;
      #2;
      test_reset();
      test_back_to_back();
      test_sbox_sweep();
      test_byte_order();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sub_byte_transform.md
Name: sub_byte_transform

Overview:
- AES-128 SubBytes stage: applies the AES forward S-box independently to each of the 16 bytes of a 128-bit state word.
- Output is registered with single-cycle latency, so the block can be used as one pipeline stage in the unrolled encryption round datapath.
- No handshake; a new state word is accepted every clock.

Parameters:
- None. Widths are fixed: 128-bit state, 16 bytes.

Ports:
- clk  input  1  System clock; all state updates on rising edge.
- rst  input  1  Reset, asynchronous, active-low. Named rst in this codebase; asserted when 0.
- dataIn  input  128 [0:127]  AES state in. Byte k occupies bits [8k:8k+7], k=0..15. Byte 0 is bits [0:7], the most significant byte of the hex literal.
- subMat  output  128 [0:127]  Registered S-box substituted state, with the same byte ordering as dataIn.

Behaviour:
- Reset:
  - While rst=0, subMat is forced to 128'h0 immediately, with no clock edge required (asynchronous clear).
  - Reset assertion mid-stream discards the pending result.
  - On deassertion (rst 0->1), the first rising clk edge loads S-box(dataIn).
- Normal operation, on each rising clk edge with rst=1:
  - subMat[8k:8k+7] <= SBOX(dataIn[8k:8k+7]) for all k=0..15.
  - Latency is exactly 1 clock: the output reflects the dataIn sampled at the previous edge.
  - Throughput is 1 state/clock.
  - Holding dataIn constant holds subMat constant after the first edge.
- SBOX:
  - The standard FIPS-197 forward S-box (multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, followed by affine transform with constant 0x63).
  - Implemented as a 256-entry constant lookup (case ROM or function), instantiated once per byte lane: 16 parallel lanes, purely combinational ahead of the register.
  - Anchor values: 00->63, 01->7C, 0E->AB, 1F->C0, 53->ED, 54->20, 8B->3D, FF->16.
- Lane independence: no byte lane depends on any other lane. No row or column mixing happens in this block.
- No X propagation from reset: subMat is never undefined after rst has been asserted once.
- Inverse S-box is out of scope (encryption only).

Test Plan:
- Reset check:
  - Hold rst=0 for 3 clocks with dataIn=001F0E543C4E08596E221B0B4774311A -> subMat = 0 throughout.
  - Release rst -> first clk edge gives subMat = 63C0AB20EB2F30CB9F93AF2BA092C7A2.
- Vector stream: apply one vector per clock -> each output appears exactly one edge later, in order.
  - 5847088B15B61CBA59D4E2E8CD39DFCE -> 6AA0303D594E9CF4CB48989BBD129E8B
  - 43C6A9620E57C0C80908EBFE3DF87F37 -> 1AB4D3AAAB5BBAE80130E9BB2741D29A
  - 7876305470767D23993C375B4B3934F1 -> BC3804205138FF26EEEB9A39B31218A1
  - B1CA51ED08FC54E104B1C9D3E7B26C20 -> C874D15530B020F8F2C8DD66943750B7
- Exhaustive S-box: sweep byte value v=00..FF replicated in all 16 lanes -> every lane equals the FIPS-197 SBOX(v) one clock later. Includes 00->63 in all lanes (output 6363...63) and FF->16 in all lanes.
- Byte ordering / lane independence:
  - dataIn=000102...0F -> subMat=637C777BF26B6FC53001672BFED7AB76.
  - Changing only byte 15 alters only subMat[120:127].
- Asynchronous reset mid-operation: drop rst between clock edges while streaming -> subMat goes to 0 immediately, without waiting for clk.
  - Output stays 0 until the first edge after release.
  - That edge gives S-box of the dataIn present at the edge.
